// File: rtl/pcie_ss_axis_pkg.sv
// Shared layout of the PCIe SS control-shadow beat, used by both the
// generator here and any decoder of the stream.
package pcie_ss_axis_pkg;

    localparam int unsigned CTRLSHDW_W      = 40;
    localparam int unsigned CTRLSHDW_PF_LSB = 0;
    localparam int unsigned CTRLSHDW_PF_W   = 3;
    localparam int unsigned CTRLSHDW_VF_LSB = 3;
    localparam int unsigned CTRLSHDW_VF_W   = 11;
    localparam int unsigned CTRLSHDW_VFA    = 14;
    localparam int unsigned CTRLSHDW_BME    = 15;
    localparam int unsigned CTRLSHDW_EXTTAG = 29;
    localparam int unsigned CTRLSHDW_TAG10  = 30;

    // Full 40-bit beat, MSB first; reserved fields are always zero.
    typedef struct packed {
        logic [8:0]  rsvd_39_31;
        logic        tag10;
        logic        ext_tag;
        logic [12:0] rsvd_28_16;
        logic        bme;
        logic        vf_active;
        logic [10:0] vf_num;
        logic [2:0]  pf_num;
    } t_pcie_ctrl_shdw;

    // Per-function shadowed config-space bits.
    typedef struct packed {
        logic bme;
        logic tag10;
        logic ext_tag;
    } t_ctrlshdw_entry;

    typedef enum logic {
        ST_IDLE,
        ST_GAP
    } t_ctrlshdw_state;

    function automatic t_pcie_ctrl_shdw ctrlshdw_encode(
        input t_ctrlshdw_entry e,
        input logic            is_vf,
        input logic [2:0]      pf,
        input logic [10:0]     vf
    );
        t_pcie_ctrl_shdw b;
        b           = '0;
        b.pf_num    = is_vf ? 3'd0 : pf;
        b.vf_num    = is_vf ? vf : 11'd0;
        b.vf_active = is_vf;
        b.bme       = e.bme;
        b.ext_tag   = e.ext_tag;
        b.tag10     = e.tag10;
        return b;
    endfunction

endpackage

// File: rtl/pcie_ctrlshdw_rr_pick.sv
// N-way round-robin picker: first set request at or after last_i+1, with wrap.
// Purely combinational; the last-grant pointer is owned by the parent.
module pcie_ctrlshdw_rr_pick #(
    parameter int unsigned N  = 12,
    parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    // Scan farthest candidate first so the nearest one after last_i wins.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = |req_i;
        for (int unsigned k = N; k >= 1; k--) begin
            if (req_i[(32'(last_i) + k) % N]) begin
                idx_o = IW'((32'(last_i) + k) % N);
                gnt_o = {{(N-1){1'b0}}, 1'b1} << ((32'(last_i) + k) % N);
            end
        end
    end

endmodule

// File: rtl/pcie_ctrlshdw_gen.sv
// Control-shadow stream generator: keeps a per-function copy of config bits
// and emits one beat per changed function, round-robin, rate-limited by MIN_GAP.
module pcie_ctrlshdw_gen
    import pcie_ss_axis_pkg::*;
#(
    parameter int unsigned NUM_PF     = 4,
    parameter int unsigned NUM_VF     = 8,
    parameter int unsigned MIN_GAP    = 2,
    parameter bit          INIT_BCAST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_wr_valid,
    input  logic [2:0]  cfg_wr_pf,
    input  logic [10:0] cfg_wr_vf,
    input  logic        cfg_wr_vf_active,
    input  logic        cfg_wr_ext_tag,
    input  logic        cfg_wr_tag10,
    input  logic        cfg_wr_bme,
    input  logic        refresh_all,
    output logic        ctrlshadow_tvalid,
    output logic [39:0] ctrlshadow_tdata,
    output logic        cfg_wr_err
);

    localparam int unsigned NF = NUM_PF + NUM_VF;
    localparam int unsigned IW = (NF > 1) ? $clog2(NF) : 1;
    localparam int unsigned GW = (MIN_GAP > 1) ? $clog2(MIN_GAP + 1) : 1;

    t_ctrlshdw_state state_q, state_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [NF-1:0]   pend_q, pend_d;
    logic [IW-1:0]   last_q, last_d;
    logic            tvalid_q, tvalid_d;
    t_pcie_ctrl_shdw tdata_q, tdata_d;
    logic            err_q, err_d;
    t_ctrlshdw_entry shadow_q [NF];

    logic            wr_ok;
    logic [IW-1:0]   wr_idx;
    logic            wr_chg;
    t_ctrlshdw_entry wr_entry;
    logic [NF-1:0]   gnt;
    logic [IW-1:0]   pick_idx;
    logic            any_pend;
    logic            pick_is_vf;

    pcie_ctrlshdw_rr_pick #(.N(NF), .IW(IW)) u_pick (
        .req_i  (pend_q),
        .last_i (last_q),
        .gnt_o  (gnt),
        .idx_o  (pick_idx),
        .any_o  (any_pend)
    );

    assign wr_entry   = '{bme: cfg_wr_bme, tag10: cfg_wr_tag10, ext_tag: cfg_wr_ext_tag};
    assign wr_chg     = cfg_wr_valid && wr_ok && (shadow_q[wr_idx] != wr_entry);
    assign pick_is_vf = (32'(pick_idx) >= NUM_PF);

    // Map the write target onto a flat function index, flagging invalid targets.
    always_comb begin
        wr_ok  = 1'b0;
        wr_idx = '0;
        if (!cfg_wr_vf_active) begin
            if (32'(cfg_wr_pf) < NUM_PF) begin
                wr_ok  = 1'b1;
                wr_idx = IW'(cfg_wr_pf);
            end
        end else if ((cfg_wr_pf == 3'd0) && (32'(cfg_wr_vf) < NUM_VF)) begin
            wr_ok  = 1'b1;
            wr_idx = IW'(NUM_PF + 32'(cfg_wr_vf));
        end
    end

    // Emission FSM and pending bookkeeping; a pick is taken combinationally in
    // IDLE so a write reaches tvalid two cycles later. Set sources override the
    // pick's clear.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        pend_d   = pend_q;
        last_d   = last_q;
        tvalid_d = 1'b0;
        tdata_d  = tdata_q;
        err_d    = err_q | (cfg_wr_valid & ~wr_ok);
        case (state_q)
            ST_IDLE: begin
                if (any_pend) begin
                    tvalid_d = 1'b1;
                    tdata_d  = ctrlshdw_encode(shadow_q[pick_idx], pick_is_vf,
                                               3'(pick_idx),
                                               11'(32'(pick_idx) - NUM_PF));
                    last_d   = pick_idx;
                    pend_d   = pend_q & ~gnt;
                    if (MIN_GAP > 1) begin
                        state_d = ST_GAP;
                        gap_d   = GW'(MIN_GAP - 1);
                    end
                end
            end
            ST_GAP: begin
                gap_d = gap_q - 1'b1;
                if (gap_q <= GW'(1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (wr_chg) begin
            pend_d[wr_idx] = 1'b1;
        end
        if (refresh_all) begin
            pend_d = '1;
        end
    end

    // State, pointer, output and shadow registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gap_q    <= '0;
            pend_q   <= INIT_BCAST ? '1 : '0;
            last_q   <= IW'(NF - 1);
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            err_q    <= 1'b0;
            for (int unsigned i = 0; i < NF; i++) begin
                shadow_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            pend_q   <= pend_d;
            last_q   <= last_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            err_q    <= err_d;
            if (cfg_wr_valid && wr_ok) begin
                shadow_q[wr_idx] <= wr_entry;
            end
        end
    end

    // Outputs are forced quiet while rst is held, even mid-beat.
    assign ctrlshadow_tvalid = tvalid_q & ~rst;
    assign ctrlshadow_tdata  = rst ? '0 : tdata_q;
    assign cfg_wr_err        = err_q;

endmodule

// File: tb/tb_pcie_ctrlshdw_gen.sv
// Directed bench for the control-shadow generator (NUM_PF=4, NUM_VF=8, MIN_GAP=2).
module tb_pcie_ctrlshdw_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_wr_valid;
    logic [2:0]  cfg_wr_pf;
    logic [10:0] cfg_wr_vf;
    logic        cfg_wr_vf_active;
    logic        cfg_wr_ext_tag;
    logic        cfg_wr_tag10;
    logic        cfg_wr_bme;
    logic        refresh_all;
    logic        ctrlshadow_tvalid;
    logic [39:0] ctrlshadow_tdata;
    logic        cfg_wr_err;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    pcie_ctrlshdw_gen #(
        .NUM_PF     (4),
        .NUM_VF     (8),
        .MIN_GAP    (2),
        .INIT_BCAST (1'b1)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .cfg_wr_valid      (cfg_wr_valid),
        .cfg_wr_pf         (cfg_wr_pf),
        .cfg_wr_vf         (cfg_wr_vf),
        .cfg_wr_vf_active  (cfg_wr_vf_active),
        .cfg_wr_ext_tag    (cfg_wr_ext_tag),
        .cfg_wr_tag10      (cfg_wr_tag10),
        .cfg_wr_bme        (cfg_wr_bme),
        .refresh_all       (refresh_all),
        .ctrlshadow_tvalid (ctrlshadow_tvalid),
        .ctrlshadow_tdata  (ctrlshadow_tdata),
        .cfg_wr_err        (cfg_wr_err)
    );

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    // Beat for function k with all shadow fields zero.
    function automatic logic [39:0] bcast_beat(input int unsigned k);
        if (k < 4) return 40'(k);
        return 40'h4000 | 40'((k - 4) << 3);
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle_in();
        cfg_wr_valid = 1'b0;
        refresh_all  = 1'b0;
    endtask

    task automatic wr(input logic vfa, input logic [2:0] pf, input logic [10:0] vf,
                      input logic bme, input logic ext, input logic t10);
        cfg_wr_valid     = 1'b1;
        cfg_wr_vf_active = vfa;
        cfg_wr_pf        = pf;
        cfg_wr_vf        = vf;
        cfg_wr_bme       = bme;
        cfg_wr_ext_tag   = ext;
        cfg_wr_tag10     = t10;
    endtask

    // Called on the negedge where rst drops; expects beats at cycles 1,3,..,23.
    task automatic expect_bcast(input string tag);
        for (int unsigned c = 1; c <= 24; c++) begin
            step();
            if (c % 2 == 1) begin
                chk({tag, "_v"}, 40'(ctrlshadow_tvalid), 40'd1);
                chk({tag, "_d"}, ctrlshadow_tdata, bcast_beat((c - 1) / 2));
            end else begin
                chk({tag, "_gap"}, 40'(ctrlshadow_tvalid), 40'd0);
            end
        end
    endtask

    logic [39:0] exp6 [6];

    initial begin
        exp6[0] = 40'h0020000002;   // PF2 ext_tag
        exp6[1] = 40'h0000000003;   // PF3
        exp6[2] = 40'h0000004000;   // VF0
        exp6[3] = 40'h0000004008;   // VF1
        exp6[4] = 40'h0000004010;   // VF2
        exp6[5] = 40'h000000C018;   // VF3 bme

        rst = 1'b1;
        cfg_wr_pf = '0; cfg_wr_vf = '0; cfg_wr_vf_active = 1'b0;
        cfg_wr_bme = 1'b0; cfg_wr_ext_tag = 1'b0; cfg_wr_tag10 = 1'b0;
        idle_in();
        repeat (3) step();
        chk("rst_tvalid", 40'(ctrlshadow_tvalid), 40'd0);
        chk("rst_tdata", ctrlshadow_tdata, 40'd0);
        chk("rst_err", 40'(cfg_wr_err), 40'd0);

        // Power-up broadcast.
        rst = 1'b0;
        expect_bcast("bcast0");

        // PF0 ext_tag+tag10: two-cycle latency, then identical write is silent.
        repeat (3) step();
        wr(1'b0, 3'd0, 11'd0, 1'b0, 1'b1, 1'b1);
        step(); idle_in();
        chk("lat_c1", 40'(ctrlshadow_tvalid), 40'd0);
        step();
        chk("lat_c2_v", 40'(ctrlshadow_tvalid), 40'd1);
        chk("lat_c2_d", ctrlshadow_tdata, 40'h0060000000);
        step();
        chk("lat_c3", 40'(ctrlshadow_tvalid), 40'd0);
        repeat (2) step();
        wr(1'b0, 3'd0, 11'd0, 1'b0, 1'b1, 1'b1);
        step(); idle_in();
        for (int unsigned i = 0; i < 4; i++) begin
            chk("same_wr", 40'(ctrlshadow_tvalid), 40'd0);
            step();
        end

        // PF2 ext_tag then VF3 bme in consecutive cycles.
        wr(1'b0, 3'd2, 11'd0, 1'b0, 1'b1, 1'b0);
        step();
        chk("two_c1", 40'(ctrlshadow_tvalid), 40'd0);
        wr(1'b1, 3'd0, 11'd3, 1'b1, 1'b0, 1'b0);
        step(); idle_in();
        chk("two_pf2_v", 40'(ctrlshadow_tvalid), 40'd1);
        chk("two_pf2_d", ctrlshadow_tdata, 40'h0020000002);
        step();
        chk("two_gap", 40'(ctrlshadow_tvalid), 40'd0);
        step();
        chk("two_vf3_v", 40'(ctrlshadow_tvalid), 40'd1);
        chk("two_vf3_d", ctrlshadow_tdata, 40'h000000C018);
        step();
        chk("two_end", 40'(ctrlshadow_tvalid), 40'd0);

        // Invalid targets: pf=5 PF, then VF under pf=1.
        chk("err_pre", 40'(cfg_wr_err), 40'd0);
        wr(1'b0, 3'd5, 11'd0, 1'b1, 1'b1, 1'b1);
        step(); idle_in();
        chk("err_pf5", 40'(cfg_wr_err), 40'd1);
        for (int unsigned i = 0; i < 3; i++) begin
            chk("err_pf5_nobeat", 40'(ctrlshadow_tvalid), 40'd0);
            step();
        end
        wr(1'b1, 3'd1, 11'd0, 1'b1, 1'b0, 1'b0);
        step(); idle_in();
        for (int unsigned i = 0; i < 3; i++) begin
            chk("err_vf_nobeat", 40'(ctrlshadow_tvalid), 40'd0);
            chk("err_sticky", 40'(cfg_wr_err), 40'd1);
            step();
        end

        // Write to PF1 during its own pick: old value first, new value after.
        wr(1'b0, 3'd1, 11'd0, 1'b1, 1'b0, 1'b0);
        step();
        chk("race_c1", 40'(ctrlshadow_tvalid), 40'd0);
        wr(1'b0, 3'd1, 11'd0, 1'b1, 1'b1, 1'b0);
        step(); idle_in();
        chk("race_old_v", 40'(ctrlshadow_tvalid), 40'd1);
        chk("race_old_d", ctrlshadow_tdata, 40'h0000008001);
        step();
        chk("race_gap", 40'(ctrlshadow_tvalid), 40'd0);
        step();
        chk("race_new_v", 40'(ctrlshadow_tvalid), 40'd1);
        chk("race_new_d", ctrlshadow_tdata, 40'h0020008001);
        for (int unsigned i = 0; i < 3; i++) begin
            step();
            chk("race_once", 40'(ctrlshadow_tvalid), 40'd0);
        end

        // refresh_all, six beats from index 2, then rst mid-stream.
        step();
        refresh_all = 1'b1;
        step(); idle_in();
        chk("rf_c1", 40'(ctrlshadow_tvalid), 40'd0);
        for (int unsigned j = 0; j < 6; j++) begin
            step();
            chk("rf_v", 40'(ctrlshadow_tvalid), 40'd1);
            chk("rf_d", ctrlshadow_tdata, exp6[j]);
            if (j < 5) begin
                step();
                chk("rf_gap", 40'(ctrlshadow_tvalid), 40'd0);
            end
        end
        rst = 1'b1;
        #1;
        chk("rst_gate_v", 40'(ctrlshadow_tvalid), 40'd0);
        chk("rst_gate_d", ctrlshadow_tdata, 40'd0);
        step();
        chk("rst_hold1", 40'(ctrlshadow_tvalid), 40'd0);
        step();
        chk("rst_hold2", 40'(ctrlshadow_tvalid), 40'd0);
        chk("rst_err_clr", 40'(cfg_wr_err), 40'd0);
        rst = 1'b0;
        expect_bcast("bcast1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
